cluster_perf_cntr_target: RTL and testbench
===========================================

Name: cluster_perf_cntr_target

Overview:
- Peripheral-bus responder (target side of the XBAR_PERIPH_BUS protocol) that counts cluster performance events and exposes them as memory-mapped registers.
- Event inputs are driven by core-side event pulses, e.g. L2 load/store, L2 cycles and TCDM contention.
- Sits behind the cluster peripheral crossbar. It answers core load/store requests with the grant, registered response and error opcode semantics that the core-side demux expects.

Parameters:
- NUM_CNTRS, 5, number of event counters (1..16).
- CNTR_WIDTH, 32, width of each counter and of the cycle counter (≤ 32).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, bus data width (fixed 32).
- ID_WIDTH, 5, transaction ID width, echoed on the response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- evt_i  in  NUM_CNTRS  per-cycle event strobes; bit i counts into counter i
- req_i  in  1  request valid
- add_i  in  ADDR_WIDTH  byte address; only add_i[7:2] decoded
- wen_i  in  1  0 = write, 1 = read
- wdata_i  in  DATA_WIDTH  write data
- be_i  in  DATA_WIDTH/8  byte enables
- id_i  in  ID_WIDTH  request ID
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_rdata_o  out  DATA_WIDTH  read data
- r_opc_o  out  1  0 = OK, 1 = error
- r_id_o  out  ID_WIDTH  echoed ID

Behaviour:
- Reset (rst_i high at a clock edge):
  - All counters, CTRL, OVF, r_valid_o, r_rdata_o, r_opc_o and r_id_o are 0.
  - gnt_o is 0 while rst_i is high.
  - Reset mid-transaction drops any pending response; no r_valid_o is issued for it.
- Handshake:
  - gnt_o = req_i & ~rst_i, combinational, with zero wait states.
  - Transaction accepted in cycle T → r_valid_o = 1 in exactly cycle T+1, for one cycle. r_id_o = id_i from T.
  - Back-to-back requests produce back-to-back responses. There is no response backpressure.
- Register map (word offset add_i[7:2]):
  - 0x00 CTRL
    - bit0 EN, global count enable, R/W.
    - bit1 CLR, write-1 pulse that clears all counters and OVF; reads 0.
  - 0x04 OVF: sticky overflow bit per counter. Bit NUM_CNTRS is the cycle counter. Write-1-to-clear.
  - 0x08 CYCLE: increments every cycle while EN = 1. R/W.
  - 0x10 + 4*i: event counter i, i < NUM_CNTRS. R/W.
  - Any other offset → r_opc_o = 1, r_rdata_o = 0. A write to such an offset has no effect.
- Reads:
  - r_rdata_o holds the register value as of cycle T, before that cycle's increment.
  - Bits above CNTR_WIDTH read 0.
  - A read of a write-only field returns 0.
- Writes: byte-lane merge under be_i. be_i = 0 is a legal no-op that still receives an OK response.
- Counting: counter i += 1 when EN & evt_i[i].
  - At all-ones the counter wraps to 0 and sets OVF[i] in the same cycle.
- Priority in one cycle, per counter:
  - CLR beats a bus write, which beats an increment.
  - A bus write to a counter suppresses that counter's increment in that cycle.
  - OVF: a set from a wrap beats a W1C clear. CLR beats both.
- An EN write takes effect from cycle T+1; events in cycle T use the old EN.

Decomposition:
- Package cluster_perf_cntr_pkg holds:
  - register offset localparams (CTRL, OVF, CYCLE, CNTR_BASE);
  - CTRL bit indices;
  - the response struct type {valid, opc, id, rdata}.
- One sub-module, perf_cntr_cell: a counter with synchronous clear, byte-enabled load, increment, and a wrap strobe. It is instantiated NUM_CNTRS + 1 times; the extra instance is the cycle counter.

Test Plan:
- Reset then read 0x10 → gnt_o in the same cycle; r_valid_o at T+1 with rdata 0, opc 0, r_id_o = id_i.
- Write CTRL = 1, pulse evt_i[2] for 7 cycles, read 0x18 → 7. Read 0x10 → 0.
- Write 0x10 = 0xFFFF_FFFE, hold evt_i[0] for 3 cycles → counter reads 1 and OVF bit0 = 1. Write OVF = 1 → OVF reads 0.
- Write 0x14 = 0x0000_00AA with be = 4'b0001 in the same cycle as evt_i[1] = 1 (prior value 0x1234_5600) → reads 0x1234_56AA, increment suppressed.
- Read offset 0x40, then write offset 0x40 → r_opc_o = 1 with rdata 0; no register changes. Back-to-back requests give consecutive r_valid_o with matching IDs.
- While counting, write CTRL = 2 (CLR) with evt_i all ones → all counters and OVF read 0 the next cycle. Assert rst_i in the cycle after a read is granted → no r_valid_o.

Source files
------------

// File: rtl/cluster_perf_cntr_pkg.sv
// Shared definitions for the cluster performance-counter peripheral target:
// register word offsets, CTRL bit positions and the registered response record.
package cluster_perf_cntr_pkg;

   // Word offsets (add_i[7:2]); byte offsets are 0x00, 0x04, 0x08, 0x10
   localparam logic [5:0] REG_CTRL      = 6'h00;
   localparam logic [5:0] REG_OVF       = 6'h01;
   localparam logic [5:0] REG_CYCLE     = 6'h02;
   localparam logic [5:0] REG_CNTR_BASE = 6'h04;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT = 1;

   localparam int unsigned RSP_ID_MAX = 16;

   typedef struct packed {
      logic                  valid;
      logic                  opc;
      logic [RSP_ID_MAX-1:0] id;
      logic [31:0]           rdata;
   } rsp_t;

endpackage

// File: rtl/perf_cntr_cell.sv
// One performance counter: synchronous clear, byte-enabled bus load and
// increment, in that priority order; wrap_o flags an all-ones increment.
module perf_cntr_cell
   import cluster_perf_cntr_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [31:0]      wdata_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]      merged;

   always_comb begin
      merged            = '0;
      merged[WIDTH-1:0] = cnt_q;
      for (int unsigned b = 0; b < 4; b++) begin
         if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
      end
      cnt_d  = cnt_q;
      wrap_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (we_i) begin
         cnt_d = merged[WIDTH-1:0];
      end else if (inc_i) begin
         cnt_d  = cnt_q + WIDTH'(1);
         wrap_o = &cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cluster_perf_cntr_target.sv
// Peripheral-bus target exposing cluster event counters, a cycle counter,
// a sticky overflow register and a control register.
module cluster_perf_cntr_target
   import cluster_perf_cntr_pkg::*;
#(
   parameter int unsigned NUM_CNTRS  = 5,
   parameter int unsigned CNTR_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CNTRS-1:0]    evt_i,
   input  logic                    req_i,
   input  logic [ADDR_WIDTH-1:0]   add_i,
   input  logic                    wen_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ID_WIDTH-1:0]     id_i,
   output logic                    gnt_o,
   output logic                    r_valid_o,
   output logic [DATA_WIDTH-1:0]   r_rdata_o,
   output logic                    r_opc_o,
   output logic [ID_WIDTH-1:0]     r_id_o
);

   localparam int unsigned NCELL = NUM_CNTRS + 1;
   localparam int unsigned CYC   = NUM_CNTRS;

   logic                  acc, rd, wr;
   logic [5:0]            word;
   logic                  hit_ctrl, hit_ovf, hit_cyc, hit_cntr, hit_any;
   logic                  clr;
   logic                  en_q, en_d;
   logic [NCELL-1:0]      ovf_q, ovf_d;
   logic [NCELL-1:0]      cell_we, cell_inc, cell_wrap;
   logic [CNTR_WIDTH-1:0] cell_val [NCELL];
   logic [DATA_WIDTH-1:0] rd_val;
   rsp_t                  rsp_q, rsp_d;
   logic                  unused_ok;

   assign gnt_o = req_i & ~rst_i;
   assign acc   = gnt_o;
   assign wr    = acc & ~wen_i;
   assign rd    = acc & wen_i;
   assign word  = add_i[7:2];

   always_comb begin
      hit_ctrl = (word == REG_CTRL);
      hit_ovf  = (word == REG_OVF);
      hit_cyc  = (word == REG_CYCLE);
      hit_cntr = 1'b0;
      cell_we  = '0;
      cell_inc = '0;
      for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
         if (word == REG_CNTR_BASE + 6'(i)) begin
            hit_cntr   = 1'b1;
            cell_we[i] = wr;
         end
         cell_inc[i] = en_q & evt_i[i];
      end
      cell_we[CYC]  = wr & hit_cyc;
      cell_inc[CYC] = en_q;
      hit_any = hit_ctrl | hit_ovf | hit_cyc | hit_cntr;
   end

   assign clr = wr & hit_ctrl & be_i[0] & wdata_i[CTRL_CLR_BIT];

   always_comb begin
      en_d = en_q;
      if (wr & hit_ctrl & be_i[0]) en_d = wdata_i[CTRL_EN_BIT];
   end

   // W1C first, then wrap sets on top so a same-cycle wrap survives; CLR overrides all
   always_comb begin
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < NCELL; i++) begin
         if (wr & hit_ovf & be_i[i/8] & wdata_i[i]) ovf_d[i] = 1'b0;
      end
      ovf_d = ovf_d | cell_wrap;
      if (clr) ovf_d = '0;
   end

   for (genvar g = 0; g < NCELL; g++) begin : g_cell
      perf_cntr_cell #(
         .WIDTH(CNTR_WIDTH)
      ) u_cell (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .clr_i  (clr),
         .inc_i  (cell_inc[g]),
         .we_i   (cell_we[g]),
         .be_i   (be_i),
         .wdata_i(wdata_i),
         .cnt_o  (cell_val[g]),
         .wrap_o (cell_wrap[g])
      );
   end

   always_comb begin
      rd_val = '0;
      if (hit_ctrl) begin
         rd_val[CTRL_EN_BIT] = en_q;
      end else if (hit_ovf) begin
         rd_val[NCELL-1:0] = ovf_q;
      end else if (hit_cyc) begin
         rd_val[CNTR_WIDTH-1:0] = cell_val[CYC];
      end else begin
         for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
            if (word == REG_CNTR_BASE + 6'(i)) rd_val[CNTR_WIDTH-1:0] = cell_val[i];
         end
      end
   end

   always_comb begin
      rsp_d                   = '0;
      rsp_d.valid             = acc;
      rsp_d.opc               = acc & ~hit_any;
      rsp_d.id[ID_WIDTH-1:0]  = id_i;
      rsp_d.rdata             = (rd & hit_any) ? rd_val : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q  <= 1'b0;
         ovf_q <= '0;
         rsp_q <= '0;
      end else begin
         en_q  <= en_d;
         ovf_q <= ovf_d;
         rsp_q <= rsp_d;
      end
   end

   // Masking with rst_i drops a response whose request was granted just before reset
   assign r_valid_o = rsp_q.valid & ~rst_i;
   assign r_opc_o   = rsp_q.opc;
   assign r_id_o    = rsp_q.id[ID_WIDTH-1:0];
   assign r_rdata_o = rsp_q.rdata;

   assign unused_ok = ^{add_i[ADDR_WIDTH-1:8], add_i[1:0], rsp_q.id};

endmodule

// File: tb/tb_cluster_perf_cntr_target.sv
// Table-driven bench with a response scoreboard for cluster_perf_cntr_target.
module tb_cluster_perf_cntr_target;

   localparam int unsigned NC = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NC-1:0] evt_i;
   logic          req_i;
   logic [31:0]   add_i;
   logic          wen_i;
   logic [31:0]   wdata_i;
   logic [3:0]    be_i;
   logic [4:0]    id_i;
   logic          gnt_o;
   logic          r_valid_o;
   logic [31:0]   r_rdata_o;
   logic          r_opc_o;
   logic [4:0]    r_id_o;

   always #5 clk_i = ~clk_i;

   cluster_perf_cntr_target #(
      .NUM_CNTRS (NC),
      .CNTR_WIDTH(32),
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .ID_WIDTH  (5)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .evt_i    (evt_i),
      .req_i    (req_i),
      .add_i    (add_i),
      .wen_i    (wen_i),
      .wdata_i  (wdata_i),
      .be_i     (be_i),
      .id_i     (id_i),
      .gnt_o    (gnt_o),
      .r_valid_o(r_valid_o),
      .r_rdata_o(r_rdata_o),
      .r_opc_o  (r_opc_o),
      .r_id_o   (r_id_o)
   );

   typedef struct {
      logic [4:0]  id;
      logic        opc;
      logic [31:0] rdata;
      int unsigned due;
   } exp_t;

   typedef struct {
      logic [NC-1:0] evt;
      logic          wen;
      logic [7:0]    addr;
      logic [31:0]   wdata;
      logic [3:0]    be;
      logic          opc;
      logic [31:0]   rdata;
      logic [NC-1:0] post_evt;
      int unsigned   post_n;
   } vec_t;

   exp_t        sb[$];
   vec_t        tv[$];
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;
   logic [4:0]  id_ctr;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [4:0] id, input logic opc,
                        input logic [31:0] rdata, input bit expect_rsp);
      exp_t e;
      req_i   = 1'b1;
      wen_i   = wen;
      add_i   = {24'h0, addr};
      wdata_i = wdata;
      be_i    = be;
      id_i    = id;
      if (expect_rsp) begin
         e.id    = id;
         e.opc   = opc;
         e.rdata = rdata;
         e.due   = cyc + 1;
         sb.push_back(e);
      end
      #1 chk("gnt", {31'b0, gnt_o}, 32'd1);
      @(negedge clk_i);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
      issue(1'b1, addr, 32'h0, 4'hF, id_ctr, 1'b0, exp, 1'b1);
      id_ctr++;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
      issue(1'b0, addr, data, be, id_ctr, 1'b0, 32'h0, 1'b1);
      id_ctr++;
   endtask

   function automatic vec_t vr(input logic [7:0] addr, input logic opc, input logic [31:0] exp);
      vec_t v;
      v = '{evt: '0, wen: 1'b1, addr: addr, wdata: 32'h0, be: 4'hF, opc: opc, rdata: exp,
            post_evt: '0, post_n: 0};
      return v;
   endfunction

   function automatic vec_t vw(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic opc);
      vec_t v;
      v = '{evt: '0, wen: 1'b0, addr: addr, wdata: data, be: be, opc: opc, rdata: 32'h0,
            post_evt: '0, post_n: 0};
      return v;
   endfunction

   // Response monitor: every r_valid_o must match the oldest expectation, on its due cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (r_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_rsp: actual r_valid_o=1 id=%0d required no response", r_id_o);
            end else begin
               e = sb.pop_front();
               chk("rsp_cycle", cyc, e.due);
               chk("rsp_id", {27'b0, r_id_o}, {27'b0, e.id});
               chk("rsp_opc", {31'b0, r_opc_o}, {31'b0, e.opc});
               chk("rsp_rdata", r_rdata_o, e.rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: actual simulation still running required finished");
      $fatal(1);
   end

   initial begin
      vec_t v;
      rst_i = 1'b1; req_i = 1'b1; evt_i = '0; add_i = '0; wen_i = 1'b1;
      wdata_i = '0; be_i = '0; id_i = 5'd9;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
      chk("rst_rvalid", {31'b0, r_valid_o}, 32'd0);
      chk("rst_rdata", r_rdata_o, 32'd0);
      chk("rst_opc", {31'b0, r_opc_o}, 32'd0);
      chk("rst_id", {27'b0, r_id_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0; req_i = 1'b0;
      @(negedge clk_i);

      tv.push_back(vr(8'h10, 1'b0, 32'h0));
      tv.push_back(vr(8'h00, 1'b0, 32'h0));
      tv.push_back(vr(8'h04, 1'b0, 32'h0));
      tv.push_back(vr(8'h08, 1'b0, 32'h0));
      v = vw(8'h00, 32'h1, 4'hF, 1'b0); v.post_evt = 5'h04; v.post_n = 7; tv.push_back(v);
      tv.push_back(vr(8'h18, 1'b0, 32'd7));
      tv.push_back(vr(8'h10, 1'b0, 32'h0));
      v = vw(8'h10, 32'hFFFF_FFFE, 4'hF, 1'b0); v.post_evt = 5'h01; v.post_n = 3; tv.push_back(v);
      tv.push_back(vr(8'h10, 1'b0, 32'h1));
      tv.push_back(vr(8'h04, 1'b0, 32'h1));
      tv.push_back(vw(8'h04, 32'h1, 4'hF, 1'b0));
      tv.push_back(vr(8'h04, 1'b0, 32'h0));
      tv.push_back(vw(8'h14, 32'h1234_5600, 4'hF, 1'b0));
      v = vw(8'h14, 32'h0000_00AA, 4'h1, 1'b0); v.evt = 5'h02; tv.push_back(v);
      tv.push_back(vr(8'h14, 1'b0, 32'h1234_56AA));
      tv.push_back(vr(8'h40, 1'b1, 32'h0));
      tv.push_back(vw(8'h40, 32'hDEAD_BEEF, 4'hF, 1'b1));
      tv.push_back(vr(8'h0C, 1'b1, 32'h0));
      tv.push_back(vr(8'h24, 1'b1, 32'h0));
      tv.push_back(vr(8'h20, 1'b0, 32'h0));
      tv.push_back(vw(8'h18, 32'hFFFF_FFFF, 4'h0, 1'b0));
      tv.push_back(vr(8'h18, 1'b0, 32'd7));
      tv.push_back(vr(8'h00, 1'b0, 32'h1));
      tv.push_back(vw(8'h00, 32'h0, 4'hF, 1'b0));
      tv.push_back(vw(8'h08, 32'd5, 4'hF, 1'b0));
      tv.push_back(vr(8'h08, 1'b0, 32'd5));
      tv.push_back(vr(8'h04, 1'b0, 32'h0));

      for (int i = 0; i < tv.size(); i++) begin
         evt_i = tv[i].evt;
         issue(tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].be, 5'(i), tv[i].opc, tv[i].rdata, 1'b1);
         evt_i = '0;
         if (tv[i].post_n > 0) begin
            req_i = 1'b0;
            evt_i = tv[i].post_evt;
            repeat (tv[i].post_n) @(negedge clk_i);
            evt_i = '0;
         end
      end
      req_i = 1'b0;
      @(negedge clk_i);
      id_ctr = 5'd27;

      // CLR while every event is active, with a live overflow bit
      wr(8'h00, 32'h1, 4'hF);
      wr(8'h10, 32'hFFFF_FFFF, 4'hF);
      req_i = 1'b0;
      evt_i = '1;
      repeat (2) @(negedge clk_i);
      wr(8'h00, 32'h2, 4'hF);
      evt_i = '0;
      for (int k = 0; k < NC; k++) rd(8'h10 + 8'(4 * k), 32'h0);
      rd(8'h04, 32'h0);
      rd(8'h08, 32'h0);
      rd(8'h00, 32'h0);

      // EN write: events in the write cycle see the old EN
      evt_i = 5'h08;
      wr(8'h00, 32'h1, 4'hF);
      evt_i = '0;
      rd(8'h1C, 32'h0);
      req_i = 1'b0;
      evt_i = 5'h08;
      @(negedge clk_i);
      evt_i = '0;
      rd(8'h1C, 32'h1);

      // Reset right after a granted read: its response must not appear
      issue(1'b1, 8'h1C, 32'h0, 4'hF, 5'd30, 1'b0, 32'h1, 1'b0);
      rst_i = 1'b1;
      #1 chk("rst_gnt2", {31'b0, gnt_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      req_i = 1'b0;
      @(negedge clk_i);
      rd(8'h1C, 32'h0);
      rd(8'h00, 32'h0);
      req_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("drain", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
